// File: rtl/mbisr_repair_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mbisr_repair_unit_if
// Description : Bundle of the MBIST fail stream, functional port, SRAM port
//               and repair status signals around mbisr_repair_unit.
//               slave  - view of the repair unit itself.
//               master - view of the surrounding logic (MBIST, functional
//                        master and SRAM).
// Ports       : bist_start, bist_done, fail_valid, fail_addr  (MBIST side)
//               sys_en, sys_we, sys_addr, sys_wdata, sys_rdata (functional)
//               mem_en, mem_we, mem_addr, mem_wdata, mem_rdata (SRAM)
//               repair_ok, repair_fail, spares_used            (status)
// Revision    : 1.0 - initial release
// ============================================================================
interface mbisr_repair_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  bist_start;
  logic                  bist_done;
  logic                  fail_valid;
  logic [ADDR_WIDTH-1:0] fail_addr;

  logic                  sys_en;
  logic                  sys_we;
  logic [ADDR_WIDTH-1:0] sys_addr;
  logic [DATA_WIDTH-1:0] sys_wdata;
  logic [DATA_WIDTH-1:0] sys_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  repair_ok;
  logic                  repair_fail;
  logic [3:0]            spares_used;

  modport slave (
    input  bist_start, bist_done, fail_valid, fail_addr,
    input  sys_en, sys_we, sys_addr, sys_wdata,
    output sys_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output repair_ok, repair_fail, spares_used
  );

  modport master (
    output bist_start, bist_done, fail_valid, fail_addr,
    output sys_en, sys_we, sys_addr, sys_wdata,
    input  sys_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  repair_ok, repair_fail, spares_used
  );
endinterface
`default_nettype wire

// File: rtl/mbisr_repair_unit.sv
`default_nettype none
// ============================================================================
// Module      : mbisr_repair_unit
// Description : Built-in self-repair stage. Collects distinct faulty word
//               addresses from the MBIST fail stream into a small fault
//               table, then redirects functional accesses to those addresses
//               into spare registers. Before repair (IDLE/COLLECT) it is a
//               pure passthrough so MBIST can exercise the raw array.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - mbisr_repair_unit_if.slave (MBIST, functional,
//                        SRAM and status signals)
// Revision    : 1.0 - initial release
// ============================================================================
module mbisr_repair_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SPARES = 4   // 1..8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mbisr_repair_unit_if.slave bus
);

  localparam int IDX_W = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_COLLECT      = 2'd1,
    ST_REPAIRED     = 2'd2,
    ST_UNREPAIRABLE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SPARES-1:0] valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] tag_q   [NUM_SPARES];
  logic [ADDR_WIDTH-1:0] tag_d   [NUM_SPARES];
  logic [DATA_WIDTH-1:0] spare_q [NUM_SPARES];
  logic [DATA_WIDTH-1:0] spare_d [NUM_SPARES];
  logic                  ovf_q, ovf_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] hit_data_q, hit_data_d;
  logic                  repair_ok_q, repair_ok_d;
  logic                  repair_fail_q, repair_fail_d;
  logic [3:0]            spares_used_q, spares_used_d;

  logic [NUM_SPARES-1:0] fail_match;
  logic [NUM_SPARES-1:0] sys_match;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      hit_idx;
  logic                  table_full;
  logic                  remap_en;
  logic                  sys_hit;

  // Per-entry address comparators for the fail stream and the functional port.
  generate
    for (genvar g = 0; g < NUM_SPARES; g++) begin : g_match
      assign fail_match[g] = valid_q[g] && (tag_q[g] == bus.fail_addr);
      assign sys_match[g]  = valid_q[g] && (tag_q[g] == bus.sys_addr);
    end
  endgenerate

  // Scan from the top down so the last assignment wins: lowest free index.
  // Entries are distinct, so at most one sys_match bit is set.
  always_comb begin
    free_idx = '0;
    hit_idx  = '0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
      if (sys_match[i]) hit_idx = IDX_W'(i);
    end
  end

  assign table_full = &valid_q;
  assign remap_en   = (state_q == ST_REPAIRED) || (state_q == ST_UNREPAIRABLE);
  assign sys_hit    = remap_en && bus.sys_en && (|sys_match);

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    spare_d       = spare_q;
    ovf_d         = ovf_q;
    hit_d         = 1'b0;
    hit_data_d    = hit_data_q;
    spares_used_d = 4'd0;

    if (bus.bist_start) begin
      // Spare data is kept; only the table contents are invalidated.
      valid_d = '0;
      ovf_d   = 1'b0;
      state_d = ST_COLLECT;
    end else if (state_q == ST_COLLECT) begin
      if (bus.fail_valid && !(|fail_match)) begin
        if (table_full) begin
          ovf_d = 1'b1;
        end else begin
          tag_d[free_idx]   = bus.fail_addr;
          valid_d[free_idx] = 1'b1;
        end
      end
      // Uses ovf_d so a fail arriving with bist_done still counts.
      if (bus.bist_done) begin
        state_d = ovf_d ? ST_UNREPAIRABLE : ST_REPAIRED;
      end
    end

    if (sys_hit) begin
      if (bus.sys_we) begin
        spare_d[hit_idx] = bus.sys_wdata;
      end else begin
        hit_d      = 1'b1;
        hit_data_d = spare_q[hit_idx];
      end
    end

    repair_ok_d   = (state_d == ST_REPAIRED);
    repair_fail_d = (state_d == ST_UNREPAIRABLE);
    for (int i = 0; i < NUM_SPARES; i++) begin
      spares_used_d = spares_used_d + {3'b000, valid_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      valid_q       <= '0;
      ovf_q         <= 1'b0;
      hit_q         <= 1'b0;
      hit_data_q    <= '0;
      repair_ok_q   <= 1'b0;
      repair_fail_q <= 1'b0;
      spares_used_q <= 4'd0;
      for (int i = 0; i < NUM_SPARES; i++) begin
        tag_q[i]   <= '0;
        spare_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      ovf_q         <= ovf_d;
      hit_q         <= hit_d;
      hit_data_q    <= hit_data_d;
      repair_ok_q   <= repair_ok_d;
      repair_fail_q <= repair_fail_d;
      spares_used_q <= spares_used_d;
      tag_q         <= tag_d;
      spare_q       <= spare_d;
    end
  end

  // A hit keeps the access away from the (faulty) SRAM word entirely.
  assign bus.mem_en      = bus.sys_en && !sys_hit;
  assign bus.mem_we      = bus.sys_we && !sys_hit;
  assign bus.mem_addr    = bus.sys_addr;
  assign bus.mem_wdata   = bus.sys_wdata;

  // SRAM data is already one cycle late, matching the registered spare path.
  assign bus.sys_rdata   = hit_q ? hit_data_q : bus.mem_rdata;

  assign bus.repair_ok   = repair_ok_q;
  assign bus.repair_fail = repair_fail_q;
  assign bus.spares_used = spares_used_q;

endmodule
`default_nettype wire

// File: tb/tb_mbisr_repair_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbisr_repair_unit
// Description : Directed testbench for mbisr_repair_unit with a behavioural
//               synchronous SRAM and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbisr_repair_unit;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbisr_repair_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mbisr_repair_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_SPARES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // SRAM model: word i holds 0x40+i after reset, except word 0 = 0x11.
  logic [DW-1:0] sram [2**AW];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_rdata <= '0;
      for (int i = 0; i < 2**AW; i++) sram[i] <= 8'h40 + 8'(i);
      sram[0] <= 8'h11;
    end else if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= sram[bus.mem_addr];
    end
  end

  // Scoreboard: each issued read pushes its expected data; the monitor pops
  // one entry on the cycle the read data is due.
  typedef struct {
    logic [DW-1:0] exp;
    string         name;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic rd_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= bus.sys_en && !bus.sys_we;
  end

  always @(negedge clk) begin
    if (rst_n && rd_pend) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_read: got 0x%0h expected no read data", bus.sys_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        check(mon_e.name, 32'(bus.sys_rdata), 32'(mon_e.exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.bist_start = 1'b0;
    bus.bist_done  = 1'b0;
    bus.fail_valid = 1'b0;
    bus.fail_addr  = '0;
    bus.sys_en     = 1'b0;
    bus.sys_we     = 1'b0;
    bus.sys_addr   = '0;
    bus.sys_wdata  = '0;
  endtask

  task automatic bist_start_pulse();
    bus.bist_start = 1'b1;
    tick();
    bus.bist_start = 1'b0;
  endtask

  task automatic fail(input logic [AW-1:0] a);
    bus.fail_valid = 1'b1;
    bus.fail_addr  = a;
    tick();
    bus.fail_valid = 1'b0;
  endtask

  task automatic bist_done_pulse();
    bus.bist_done = 1'b1;
    tick();
    bus.bist_done = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic exp_en, input logic exp_we, input string name);
    bus.sys_en    = 1'b1;
    bus.sys_we    = 1'b1;
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    #1;
    check({name, "_mem_en"}, 32'(bus.mem_en), 32'(exp_en));
    check({name, "_mem_we"}, 32'(bus.mem_we), 32'(exp_we));
    tick();
    bus.sys_en = 1'b0;
    bus.sys_we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    bus.sys_en   = 1'b1;
    bus.sys_we   = 1'b0;
    bus.sys_addr = a;
    tick();
    bus.sys_en = 1'b0;
  endtask

  task automatic check_status(input logic ok, input logic fl, input logic [3:0] used, input string name);
    check({name, "_repair_ok"},   32'(bus.repair_ok),   32'(ok));
    check({name, "_repair_fail"}, 32'(bus.repair_fail), 32'(fl));
    check({name, "_spares_used"}, 32'(bus.spares_used), 32'(used));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] five_fails [5];
    five_fails = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
    idle_inputs();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_status(1'b0, 1'b0, 4'd0, "reset");
    check("reset_sys_rdata", 32'(bus.sys_rdata), 32'h0);
    rst_n = 1'b1;
    tick();

    // Fail stream 3,7,3: the duplicate does not take an entry
    bist_start_pulse();
    fail(5'd3);
    fail(5'd7);
    fail(5'd3);
    check("t1_collect_used", 32'(bus.spares_used), 32'd2);
    bist_done_pulse();
    check_status(1'b1, 1'b0, 4'd2, "t1");
    do_write(5'd7, 8'hA5, 1'b0, 1'b0, "t1_wr7");
    do_read(5'd7, 8'hA5, "t1_rd7");
    do_read(5'd5, 8'h45, "t1_rd5_miss");

    // Alternating miss/hit reads and read-after-write on a spare
    do_write(5'd3, 8'h5A, 1'b0, 1'b0, "t5_wr3");
    do_read(5'd0, 8'h11, "t5_rd0_a");
    do_read(5'd3, 8'h5A, "t5_rd3_a");
    do_read(5'd0, 8'h11, "t5_rd0_b");
    do_read(5'd3, 8'h5A, "t5_rd3_b");
    do_write(5'd3, 8'h77, 1'b0, 1'b0, "t5_wr3_new");
    do_read(5'd3, 8'h77, "t5_raw3");

    // fail_valid outside COLLECT is ignored
    fail(5'd20);
    check_status(1'b1, 1'b0, 4'd2, "ignored_fail");

    // bist_start wins over a coincident fail; passthrough resumes
    bus.bist_start = 1'b1;
    bus.fail_valid = 1'b1;
    bus.fail_addr  = 5'd12;
    tick();
    bus.bist_start = 1'b0;
    bus.fail_valid = 1'b0;
    check_status(1'b0, 1'b0, 4'd0, "t4_restart");
    do_write(5'd7, 8'h3C, 1'b1, 1'b1, "t4_wr7_pass");
    do_read(5'd7, 8'h3C, "t4_rd7_pass");
    bist_done_pulse();
    check_status(1'b1, 1'b0, 4'd0, "t4_done");
    // Earlier writes to addr 3 went to the spare, so SRAM still holds 0x43.
    do_read(5'd3, 8'h43, "t4_rd3_sram");

    // Five distinct fails with four spares
    bist_start_pulse();
    foreach (five_fails[i]) fail(five_fails[i]);
    bist_done_pulse();
    check_status(1'b0, 1'b1, 4'd4, "t2");
    do_write(5'd1, 8'hC1, 1'b0, 1'b0, "t2_wr1");
    do_read(5'd1, 8'hC1, "t2_rd1");
    // Entry 1 (now addr 2) still carries 0xA5 from the earlier addr-7 write.
    do_read(5'd2, 8'hA5, "t2_rd2_spare");
    do_read(5'd4, 8'h00, "t2_rd4_spare");
    do_write(5'd16, 8'h66, 1'b1, 1'b1, "t2_wr16_pass");
    do_read(5'd16, 8'h66, "t2_rd16_pass");

    // Last fail coincident with bist_done
    bist_start_pulse();
    fail(5'd5);
    fail(5'd6);
    fail(5'd10);
    check("t3_used3", 32'(bus.spares_used), 32'd3);
    bus.fail_valid = 1'b1;
    bus.fail_addr  = 5'd9;
    bus.bist_done  = 1'b1;
    tick();
    bus.fail_valid = 1'b0;
    bus.bist_done  = 1'b0;
    check_status(1'b1, 1'b0, 4'd4, "t3");
    do_read(5'd9, 8'h00, "t3_rd9_spare");
    do_write(5'd9, 8'h99, 1'b0, 1'b0, "t3_wr9");
    do_read(5'd9, 8'h99, "t3_rd9");

    // Reset in the middle of COLLECT
    bist_start_pulse();
    fail(5'd11);
    fail(5'd12);
    check("t6_used2", 32'(bus.spares_used), 32'd2);
    rst_n = 1'b0;
    #2;
    check_status(1'b0, 1'b0, 4'd0, "t6_reset");
    check("t6_sys_rdata", 32'(bus.sys_rdata), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    do_write(5'd11, 8'hE1, 1'b1, 1'b1, "t6_wr11_pass");
    do_read(5'd11, 8'hE1, "t6_rd11_pass");

    repeat (2) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
